// File: rtl/dt_pkg.sv
// Shared definitions for the distance-transform engine: geometry, widths, FSM encodings.
// No logic; constants and a border helper only.
// Used by the sti loader and the forward/backward engine.
package dt_pkg;

    // Image geometry
    localparam int IMG_W  = 128;
    localparam int WORD_W = 16;
    localparam int NPIX   = IMG_W * IMG_W;
    localparam int NWORD  = NPIX / WORD_W;

    // Memory address widths
    localparam int STI_AW = 10;
    localparam int RES_AW = 14;
    localparam int COL_W  = 7;

    // Default pixel values written into the res RAM
    localparam logic [7:0] OBJ_VAL_DEF = 8'd1;
    localparam logic [7:0] BG_VAL_DEF  = 8'd0;

    // sti loader states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WRITE = 2'd2,
        FIN   = 2'd3
    } ld_state_t;

    // Forward/backward engine states
    typedef enum logic [2:0] {
        FB_IDLE   = 3'd0,
        FB_FWD    = 3'd1,
        FB_FWD_WB = 3'd2,
        FB_BWD    = 3'd3,
        FB_BWD_WB = 3'd4,
        FB_DONE   = 3'd5
    } fb_state_t;

    // A pixel is on the border if its row or column is the first or last one.
    function automatic logic on_border(input logic [RES_AW-1:0] p);
        logic [COL_W-1:0] row;
        logic [COL_W-1:0] col;
        row = p[RES_AW-1 -: COL_W];
        col = p[COL_W-1:0];
        return (row == '0) || (row == '1) || (col == '0) || (col == '1);
    endfunction

endpackage

// File: rtl/dt_word_shifter.sv
// Word-to-pixel shifter: holds one sti word, MSB is the pixel currently being written.
// Latency: load/shift take effect on the next edge; nxt_msb looks one edge ahead.
// No backpressure; the loader decides every cycle whether to load, shift or hold.
module dt_word_shifter
    import dt_pkg::*;
#(
    parameter int W = WORD_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         nxt_msb,
    output logic         last_bit
);

    logic [W-1:0]         data;
    logic [$clog2(W)-1:0] bit_idx;

    // Word register and position of the current pixel inside it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data    <= '0;
            bit_idx <= '0;
        end else if (load) begin
            data    <= din;
            bit_idx <= '0;
        end else if (shift) begin
            data    <= {data[W-2:0], 1'b0};
            bit_idx <= bit_idx + 1'b1;
        end
    end

    // MSB as it will be after this edge, so the loader can register res_do
    assign nxt_msb  = load ? din[W-1] : (shift ? data[W-2] : data[W-1]);
    assign last_bit = (bit_idx == '1);

endmodule

// File: rtl/dt_sti_loader.sv
// Expands the 1-bit sti ROM image into one 8-bit pixel per res RAM location.
// Latency: 1 fetch cycle, 16384 back-to-back write cycles, then a 1-cycle done pulse.
// No backpressure: ROM and RAM are assumed single-cycle; next word is prefetched on bit 15.
module dt_sti_loader
    import dt_pkg::*;
#(
    parameter bit         CLEAR_BORDER = 1'b1,
    parameter logic [7:0] OBJ_VAL      = OBJ_VAL_DEF,
    parameter logic [7:0] BG_VAL       = BG_VAL_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              sti_rd,
    output logic [STI_AW-1:0] sti_addr,
    input  logic [WORD_W-1:0] sti_di,
    output logic              res_wr,
    output logic              res_rd,
    output logic [RES_AW-1:0] res_addr,
    output logic [7:0]        res_do,
    output logic [RES_AW:0]   obj_count
);

    localparam logic [RES_AW-1:0] LAST_PIX  = RES_AW'(NPIX - 1);
    localparam logic [STI_AW-1:0] LAST_WORD = STI_AW'(NWORD - 1);

    ld_state_t         state;
    ld_state_t         state_nxt;
    logic [RES_AW-1:0] pix;
    logic [RES_AW-1:0] pix_nxt;
    logic [RES_AW-1:0] pix_inc;
    logic [STI_AW-1:0] wptr;
    logic [STI_AW-1:0] wptr_nxt;

    logic              busy_nxt;
    logic              done_nxt;
    logic              sti_rd_nxt;
    logic [STI_AW-1:0] sti_addr_nxt;
    logic              res_wr_nxt;
    logic [RES_AW-1:0] res_addr_nxt;
    logic [7:0]        res_do_nxt;
    logic              obj_clr;
    logic              obj_inc;

    logic              sh_load;
    logic              sh_shift;
    logic              nxt_msb;
    logic              last_bit;
    logic [RES_AW-1:0] tgt_pix;
    logic              tgt_obj;

    // A registered sti_rd means sti_di is valid now, so the shifter loads on this edge.
    // Otherwise it advances one pixel per write cycle until the word is used up.
    assign sh_load  = sti_rd;
    assign sh_shift = (state == WRITE) && !sti_rd && !last_bit;

    dt_word_shifter #(
        .W (WORD_W)
    ) u_shifter (
        .clk      (clk),
        .reset    (reset),
        .load     (sh_load),
        .shift    (sh_shift),
        .din      (sti_di),
        .nxt_msb  (nxt_msb),
        .last_bit (last_bit)
    );

    assign pix_inc = pix + 1'b1;

    // Pixel whose write is being set up on this edge and its object/background decision
    always_comb begin
        tgt_pix = (state == FETCH) ? pix : pix_inc;
        tgt_obj = nxt_msb && !(CLEAR_BORDER && on_border(tgt_pix));
    end

    // Next state and next values of every registered output
    always_comb begin
        state_nxt    = state;
        pix_nxt      = pix;
        wptr_nxt     = wptr;
        busy_nxt     = busy;
        done_nxt     = 1'b0;
        sti_rd_nxt   = 1'b0;
        sti_addr_nxt = sti_addr;
        res_wr_nxt   = 1'b0;
        res_addr_nxt = res_addr;
        res_do_nxt   = res_do;
        obj_clr      = 1'b0;
        obj_inc      = 1'b0;

        case (state)
            IDLE: begin
                busy_nxt = 1'b0;
                if (start) begin
                    state_nxt    = FETCH;
                    busy_nxt     = 1'b1;
                    sti_rd_nxt   = 1'b1;
                    sti_addr_nxt = '0;
                    wptr_nxt     = '0;
                    pix_nxt      = '0;
                    obj_clr      = 1'b1;
                end
            end

            FETCH: begin
                // Word 0 arrives on this edge; pixel 0 goes out next cycle
                state_nxt    = WRITE;
                res_wr_nxt   = 1'b1;
                res_addr_nxt = tgt_pix;
                res_do_nxt   = tgt_obj ? OBJ_VAL : BG_VAL;
                obj_inc      = tgt_obj;
            end

            WRITE: begin
                if (sti_rd) begin
                    wptr_nxt = wptr + 1'b1;
                end
                if (pix == LAST_PIX) begin
                    state_nxt = FIN;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                end else begin
                    pix_nxt      = pix_inc;
                    res_wr_nxt   = 1'b1;
                    res_addr_nxt = tgt_pix;
                    res_do_nxt   = tgt_obj ? OBJ_VAL : BG_VAL;
                    obj_inc      = tgt_obj;
                    // Prefetch the following word during the last pixel of this one
                    if ((pix_inc[3:0] == 4'hF) && (wptr != LAST_WORD)) begin
                        sti_rd_nxt   = 1'b1;
                        sti_addr_nxt = wptr + 1'b1;
                    end
                end
            end

            FIN: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end

            default: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    // State, counters and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            pix      <= '0;
            wptr     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sti_rd   <= 1'b0;
            sti_addr <= '0;
            res_wr   <= 1'b0;
            res_addr <= '0;
            res_do   <= '0;
        end else begin
            state    <= state_nxt;
            pix      <= pix_nxt;
            wptr     <= wptr_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            sti_rd   <= sti_rd_nxt;
            sti_addr <= sti_addr_nxt;
            res_wr   <= res_wr_nxt;
            res_addr <= res_addr_nxt;
            res_do   <= res_do_nxt;
        end
    end

    // Object pixel count, cleared on start and held after done
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            obj_count <= '0;
        end else if (obj_clr) begin
            obj_count <= '0;
        end else if (obj_inc) begin
            obj_count <= obj_count + 1'b1;
        end
    end

    // This block never reads the res RAM
    assign res_rd = 1'b0;

endmodule

// File: tb/tb_dt_sti_loader.sv
// Bench for dt_sti_loader: two instances (border cleared / kept) share one ROM image.
// Each run captures every RAM write and compares it against a pixel-rule reference.
// Covers reset state, fixed and random images, mid-run reset, and a held start.
module tb_dt_sti_loader;
    import dt_pkg::*;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;

    logic [1:0]  busy;
    logic [1:0]  done;
    logic [1:0]  sti_rd;
    logic [1:0]  res_wr;
    logic [1:0]  res_rd;
    logic [9:0]  sti_addr  [2];
    logic [15:0] sti_di    [2];
    logic [13:0] res_addr  [2];
    logic [7:0]  res_do    [2];
    logic [14:0] obj_count [2];

    logic [15:0] rom [1024];
    logic [7:0]  img [2][16384];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Asynchronous ROM read: data valid in the same cycle as the address
    assign sti_di[0] = rom[sti_addr[0]];
    assign sti_di[1] = rom[sti_addr[1]];

    dt_sti_loader #(.CLEAR_BORDER(1'b1)) u_dut_cb (
        .clk(clk), .reset(reset), .start(start),
        .busy(busy[0]), .done(done[0]),
        .sti_rd(sti_rd[0]), .sti_addr(sti_addr[0]), .sti_di(sti_di[0]),
        .res_wr(res_wr[0]), .res_rd(res_rd[0]), .res_addr(res_addr[0]),
        .res_do(res_do[0]), .obj_count(obj_count[0])
    );

    dt_sti_loader #(.CLEAR_BORDER(1'b0)) u_dut_nb (
        .clk(clk), .reset(reset), .start(start),
        .busy(busy[1]), .done(done[1]),
        .sti_rd(sti_rd[1]), .sti_addr(sti_addr[1]), .sti_di(sti_di[1]),
        .res_wr(res_wr[1]), .res_rd(res_rd[1]), .res_addr(res_addr[1]),
        .res_do(res_do[1]), .obj_count(obj_count[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected pixel straight from the image rules: bit (15 - p%16) of word p/16,
    // forced to background on the border when clearing is enabled.
    function automatic logic [7:0] ref_pix(input bit cb, input int p);
        int w, b, row, col;
        bit on, brd;
        w   = p / 16;
        b   = 15 - (p % 16);
        on  = rom[w][b];
        row = p / 128;
        col = p % 128;
        brd = (row == 0) || (row == 127) || (col == 0) || (col == 127);
        return (on && !(cb && brd)) ? 8'd1 : 8'd0;
    endfunction

    task automatic chk_zero_outputs(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk({tag, "/strobes"}, {27'd0, busy[i], done[i], sti_rd[i], res_wr[i], res_rd[i]}, 32'd0);
            chk({tag, "/addr"}, {8'd0, sti_addr[i], res_addr[i]}, 32'd0);
            chk({tag, "/data"}, {9'd0, res_do[i], obj_count[i]}, 32'd0);
        end
    endtask

    // One full conversion; start is held high throughout when hold is set.
    task automatic run_image(input bit hold, input string tag);
        int k, done_k, seq_err, busy_cnt, img_err, exp_obj, idle_err, ea, addr159;
        int wr_cnt [2];
        bit fin, erd;
        logic [7:0] e;
        for (int i = 0; i < 2; i++) begin
            wr_cnt[i] = 0;
            for (int p = 0; p < 16384; p++) img[i][p] = 8'hFF;
        end
        seq_err = 0; busy_cnt = 0; done_k = -1; addr159 = -1; fin = 1'b0;

        @(negedge clk); start = 1'b1;
        @(negedge clk); if (!hold) start = 1'b0;
        k = 0;
        while (!fin && k < 20000) begin
            for (int i = 0; i < 2; i++) begin
                if (res_wr[i]) begin
                    img[i][res_addr[i]] = res_do[i];
                    wr_cnt[i]++;
                end
                if (busy[i]) busy_cnt++;
                if (res_rd[i]) seq_err++;
                if (k == 0) begin
                    if (!(sti_rd[i] && sti_addr[i] == 10'd0 && !res_wr[i] && busy[i])) seq_err++;
                end else if (k <= 16384) begin
                    ea  = k - 1;
                    erd = ((ea % 16) == 15) && ((ea / 16) < 1023);
                    if (!(res_wr[i] && res_addr[i] == 14'(ea) && busy[i] && !done[i])) seq_err++;
                    if (sti_rd[i] !== erd) seq_err++;
                    if (erd && (int'(sti_addr[i]) != ea / 16 + 1)) seq_err++;
                end else begin
                    if (res_wr[i] || busy[i] || sti_rd[i]) seq_err++;
                end
            end
            if (res_wr[0] && res_addr[0] == 14'd159) addr159 = sti_rd[0] ? int'(sti_addr[0]) : -1;
            if (done[0]) begin
                fin    = 1'b1;
                done_k = k;
                chk({tag, "/done_both"}, {31'd0, done[1]}, 32'd1);
            end else begin
                k++;
                @(negedge clk);
            end
        end

        chk({tag, "/done_cycle"}, done_k, 32'd16385);
        chk({tag, "/busy_cycles"}, busy_cnt, 32'd32770);
        chk({tag, "/writes_cb"}, wr_cnt[0], 32'd16384);
        chk({tag, "/writes_nb"}, wr_cnt[1], 32'd16384);
        chk({tag, "/sequence"}, seq_err, 32'd0);
        chk({tag, "/sti_addr_at_159"}, addr159, 32'd10);

        for (int i = 0; i < 2; i++) begin
            img_err = 0; exp_obj = 0;
            for (int p = 0; p < 16384; p++) begin
                e = ref_pix(i == 0, p);
                if (img[i][p] !== e) img_err++;
                exp_obj += int'(e);
            end
            chk({tag, (i == 0) ? "/img_cb" : "/img_nb"}, img_err, 32'd0);
            chk({tag, (i == 0) ? "/obj_cb" : "/obj_nb"}, {17'd0, obj_count[i]}, exp_obj);
        end

        // The cycle after FIN: done gone, nothing restarted even if start was high in FIN
        @(negedge clk);
        start = 1'b0;
        chk({tag, "/done_pulse"}, {30'd0, done}, 32'd0);
        chk({tag, "/busy_after"}, {30'd0, busy}, 32'd0);
        if (hold) begin
            idle_err = 0;
            repeat (20) begin
                @(negedge clk);
                if (busy != 2'b00 || sti_rd != 2'b00 || res_wr != 2'b00 || done != 2'b00) idle_err++;
            end
            chk({tag, "/no_restart"}, idle_err, 32'd0);
        end
    endtask

    initial begin
        int quiet_err;

        for (int w = 0; w < 1024; w++) rom[w] = 16'h0000;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero_outputs("reset");
        reset = 1'b1;
        @(negedge clk);
        chk_zero_outputs("idle");

        // All-zero image
        run_image(1'b0, "zeros");

        // All-ones image, with border spot checks on the cleared instance
        for (int w = 0; w < 1024; w++) rom[w] = 16'hFFFF;
        run_image(1'b0, "ones");
        chk("ones/res128", img[0][128], 32'd0);
        chk("ones/res129", img[0][129], 32'd1);
        chk("ones/res254", img[0][254], 32'd1);
        chk("ones/res255", img[0][255], 32'd0);
        chk("ones/res16383", img[0][16383], 32'd0);
        chk("ones/obj_cb_const", {17'd0, obj_count[0]}, 32'd15876);
        chk("ones/obj_nb_const", {17'd0, obj_count[1]}, 32'd16384);

        // Single word with both end bits set, start held high for the whole run
        for (int w = 0; w < 1024; w++) rom[w] = 16'h0000;
        rom[9] = 16'h8001;
        run_image(1'b1, "word9");
        chk("word9/res144", img[1][144], 32'd1);
        chk("word9/res159", img[1][159], 32'd1);
        chk("word9/res145", img[1][145], 32'd0);
        chk("word9/obj_const", {17'd0, obj_count[0]}, 32'd2);

        // Random image, aborted by reset mid-run, then a complete rerun
        for (int w = 0; w < 1024; w++) rom[w] = 16'($urandom);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (5000) @(negedge clk);
        reset = 1'b0;
        #1;
        chk_zero_outputs("midreset");
        repeat (3) @(negedge clk);
        reset = 1'b1;
        quiet_err = 0;
        repeat (100) begin
            @(negedge clk);
            if (res_wr != 2'b00 || done != 2'b00 || busy != 2'b00 || sti_rd != 2'b00) quiet_err++;
        end
        chk("midreset/quiet", quiet_err, 32'd0);
        run_image(1'b0, "rerun");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
